// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start/data/parity/stop recovery with a
// valid/ready byte output, parity/frame error sideband and overrun pulse.
module uart_rx_frame #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       s_axi_aclk,
    input  logic       s_axi_aresetn,
    input  logic       rx,
    input  logic       sample_tick,
    input  logic       data_size,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    input  logic       stop_bit_size,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rs_q, rs_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            size_q, size_d, pen_q, pen_d, stop2_q, stop2_d;
    logic [1:0]      pmode_q, pmode_d;
    logic            perr_q, perr_d, ferr_q, ferr_d;
    logic            sample, complete, par_exp;
    logic [7:0]      data_q;
    logic            valid_q, perr_out_q, ferr_out_q, overrun_q;

    // Start bit is sampled at half a bit period, every later bit a full period on.
    assign sample = sample_tick &&
                    (cnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));

    always_comb begin
        unique case (pmode_q)
            2'b11:   par_exp = ~^shreg_q;
            2'b10:   par_exp = ^shreg_q;
            2'b01:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        size_d   = size_q;
        pen_d    = pen_q;
        pmode_d  = pmode_q;
        stop2_d  = stop2_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        complete = 1'b0;
        if (sample_tick && state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
            cnt_d = sample ? '0 : cnt_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (rs_prev_q && !rs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        size_d  = data_size;
                        pen_d   = parity_en;
                        pmode_d = parity_mode;
                        stop2_d = stop_bit_size;
                        bit_d   = '0;
                        shreg_d = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d[bit_q] = rs_q;
                    if (bit_q == (size_q ? 3'd7 : 3'd6)) begin
                        state_d = pen_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (rs_q != par_exp);
                    state_d = S_STOP1;
                end
            end
            S_STOP1, S_STOP2: begin
                if (sample) begin
                    ferr_d = ferr_q | ~rs_q;
                    if (state_q == S_STOP1 && stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        complete = 1'b1;
                        state_d  = ferr_d ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            size_q    <= 1'b0;
            pen_q     <= 1'b0;
            pmode_q   <= '0;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rs_q      <= rx_meta_q;
            rs_prev_q <= rs_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            size_q    <= size_d;
            pen_q     <= pen_d;
            pmode_q   <= pmode_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // A completion that finds the held byte unaccepted is dropped, not queued.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (complete) begin
                if (!valid_q || ready) begin
                    data_q     <= shreg_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= ferr_d;
                    valid_q    <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data         = data_q;
    assign valid        = valid_q;
    assign parity_error = perr_out_q;
    assign frame_error  = ferr_out_q;
    assign overrun      = overrun_q;

endmodule
